// File: rtl/bus8_pkg.sv
// bus8_pkg: constants shared by the bus-attached dual-port RAM blocks.
package bus8_pkg;
   localparam int RD_PIPE_MIN = 1;
   localparam int RD_PIPE_MAX = 2;
   localparam int CNT_W = 8;
endpackage

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: single-clock true dual-port RAM, per-byte write enables, read-first, registered outputs.
module dual_port_ram_be #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64,
   parameter int NLANE = WIDTH/8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_en,
   input  logic [AW-1:0]    a_addr,
   input  logic [WIDTH-1:0] a_din,
   input  logic [NLANE-1:0] a_be,
   output logic [WIDTH-1:0] a_q,
   input  logic             b_en,
   input  logic [AW-1:0]    b_addr,
   input  logic [WIDTH-1:0] b_din,
   input  logic [NLANE-1:0] b_be,
   output logic [WIDTH-1:0] b_q
);
   logic [WIDTH-1:0] mem [DEPTH];
   // Callers never enable the same lane of the same word on both ports.
   always_ff @(posedge clk)
      for (int k = 0; k < NLANE; k++) begin
         if (a_be[k]) mem[a_addr][8*k +: 8] <= a_din[8*k +: 8];
         if (b_be[k]) mem[b_addr][8*k +: 8] <= b_din[8*k +: 8];
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         if (a_en) a_q <= mem[a_addr];
         if (b_en) b_q <= mem[b_addr];
      end
endmodule

// File: rtl/bus8_dpram_mw.sv
// bus8_dpram_mw: 8-bit register-bus port plus byte-enabled wide port onto one RAM,
// with selectable bus read latency and a saturating write-collision counter.
module bus8_dpram_mw
   import bus8_pkg::*;
#(
   parameter int PORTB_WIDTH = 32,
   parameter int DEPTH = 64,
   parameter int RD_PIPE = 1,
   localparam int NLANE = PORTB_WIDTH/8,
   localparam int LB = $clog2(NLANE),
   localparam int BW = $clog2(DEPTH),
   localparam int AW = BW+LB
) (
   input  logic                   i_Bus_Clk,
   input  logic                   i_Bus_Rst,
   input  logic                   i_Bus_CS,
   input  logic                   i_Bus_Wr_Rd_n,
   input  logic [AW-1:0]          i_Bus_Addr8,
   input  logic [7:0]             i_Bus_Wr_Data,
   output logic [7:0]             o_Bus_Rd_Data,
   output logic                   o_Bus_Rd_DV,
   input  logic [BW-1:0]          i_PortB_Addr,
   input  logic [PORTB_WIDTH-1:0] i_PortB_Data,
   input  logic [NLANE-1:0]       i_PortB_BE,
   input  logic                   i_PortB_WE,
   output logic [PORTB_WIDTH-1:0] o_PortB_Data,
   output logic [CNT_W-1:0]       o_Collision_Cnt
);
   localparam int LS = (LB > 0) ? LB : 1;
   logic [LS-1:0] lane, lane_q;
   logic [BW-1:0] word;
   logic bus_wr, bus_rd, collision, dv_q;
   logic [NLANE-1:0] lane_oh, a_be, b_be;
   logic [PORTB_WIDTH-1:0] a_q;
   logic [7:0] rd_byte;
   logic [CNT_W-1:0] cnt;

   generate
      if (LB > 0) begin : g_lane
         assign lane = i_Bus_Addr8[LB-1:0];
         assign word = i_Bus_Addr8[AW-1:LB];
      end else begin : g_nolane
         assign lane = '0;
         assign word = i_Bus_Addr8;
      end
   endgenerate

   // Port B owns any byte both ports write in the same clock; the bus byte is dropped.
   always_comb begin
      bus_wr = i_Bus_CS & i_Bus_Wr_Rd_n;
      bus_rd = i_Bus_CS & ~i_Bus_Wr_Rd_n;
      lane_oh = NLANE'(1) << lane;
      b_be = i_PortB_WE ? i_PortB_BE : '0;
      collision = bus_wr && (word == i_PortB_Addr) && |(lane_oh & b_be);
      a_be = (bus_wr && !collision) ? lane_oh : '0;
   end

   dual_port_ram_be #(.WIDTH(PORTB_WIDTH), .DEPTH(DEPTH), .NLANE(NLANE)) u_ram (
      .clk(i_Bus_Clk),
      .rst(i_Bus_Rst),
      .a_en(bus_rd),
      .a_addr(word),
      .a_din({NLANE{i_Bus_Wr_Data}}),
      .a_be(a_be),
      .a_q(a_q),
      .b_en(1'b1),
      .b_addr(i_PortB_Addr),
      .b_din(i_PortB_Data),
      .b_be(b_be),
      .b_q(o_PortB_Data)
   );

   // Port A output and lane only move on reads, so the selected byte holds between pulses.
   always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst)
      if (i_Bus_Rst) begin
         lane_q <= '0;
         dv_q <= 1'b0;
         cnt <= '0;
      end else begin
         dv_q <= bus_rd;
         if (bus_rd) lane_q <= lane;
         if (collision && cnt != '1) cnt <= cnt + 1'b1;
      end

   assign rd_byte = a_q[8*lane_q +: 8];
   assign o_Collision_Cnt = cnt;

   generate
      if (RD_PIPE == RD_PIPE_MAX) begin : g_pipe2
         logic [7:0] data_q;
         logic dv2_q;
         always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst)
            if (i_Bus_Rst) begin
               data_q <= '0;
               dv2_q <= 1'b0;
            end else begin
               dv2_q <= dv_q;
               if (dv_q) data_q <= rd_byte;
            end
         assign o_Bus_Rd_Data = data_q;
         assign o_Bus_Rd_DV = dv2_q;
      end else begin : g_pipe1
         assign o_Bus_Rd_Data = rd_byte;
         assign o_Bus_Rd_DV = dv_q;
      end
   endgenerate
endmodule

// File: tb/tb_bus8_dpram_mw.sv
// tb_bus8_dpram_mw: directed and randomized checks of bus8_dpram_mw in three parameterisations.
module tb_bus8_dpram_mw;
   logic clk = 1'b0;
   logic rst;
   int total = 0;
   int bad = 0;

   logic c0_cs, c0_wr, c0_dv, c0_we;
   logic [7:0] c0_addr, c0_wd, c0_rd, c0_cnt;
   logic [5:0] c0_ba;
   logic [31:0] c0_bd, c0_bq;
   logic [3:0] c0_be;

   logic c1_cs, c1_wr, c1_dv, c1_we;
   logic [7:0] c1_addr, c1_wd, c1_rd, c1_cnt;
   logic [5:0] c1_ba;
   logic [31:0] c1_bd, c1_bq;
   logic [3:0] c1_be;

   logic c2_cs, c2_wr, c2_dv, c2_we;
   logic [7:0] c2_addr, c2_wd, c2_rd, c2_cnt, c2_ba, c2_bd, c2_bq;
   logic [0:0] c2_be;

   always #5 clk = ~clk;

   bus8_dpram_mw #(.PORTB_WIDTH(32), .DEPTH(64), .RD_PIPE(1)) u0 (
      .i_Bus_Clk(clk), .i_Bus_Rst(rst), .i_Bus_CS(c0_cs), .i_Bus_Wr_Rd_n(c0_wr),
      .i_Bus_Addr8(c0_addr), .i_Bus_Wr_Data(c0_wd), .o_Bus_Rd_Data(c0_rd), .o_Bus_Rd_DV(c0_dv),
      .i_PortB_Addr(c0_ba), .i_PortB_Data(c0_bd), .i_PortB_BE(c0_be), .i_PortB_WE(c0_we),
      .o_PortB_Data(c0_bq), .o_Collision_Cnt(c0_cnt));

   bus8_dpram_mw #(.PORTB_WIDTH(32), .DEPTH(64), .RD_PIPE(2)) u1 (
      .i_Bus_Clk(clk), .i_Bus_Rst(rst), .i_Bus_CS(c1_cs), .i_Bus_Wr_Rd_n(c1_wr),
      .i_Bus_Addr8(c1_addr), .i_Bus_Wr_Data(c1_wd), .o_Bus_Rd_Data(c1_rd), .o_Bus_Rd_DV(c1_dv),
      .i_PortB_Addr(c1_ba), .i_PortB_Data(c1_bd), .i_PortB_BE(c1_be), .i_PortB_WE(c1_we),
      .o_PortB_Data(c1_bq), .o_Collision_Cnt(c1_cnt));

   bus8_dpram_mw #(.PORTB_WIDTH(8), .DEPTH(256), .RD_PIPE(1)) u2 (
      .i_Bus_Clk(clk), .i_Bus_Rst(rst), .i_Bus_CS(c2_cs), .i_Bus_Wr_Rd_n(c2_wr),
      .i_Bus_Addr8(c2_addr), .i_Bus_Wr_Data(c2_wd), .o_Bus_Rd_Data(c2_rd), .o_Bus_Rd_DV(c2_dv),
      .i_PortB_Addr(c2_ba), .i_PortB_Data(c2_bd), .i_PortB_BE(c2_be), .i_PortB_WE(c2_we),
      .o_PortB_Data(c2_bq), .o_Collision_Cnt(c2_cnt));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      c0_cs = 0; c0_wr = 0; c0_we = 0; c0_be = '0;
      c1_cs = 0; c1_wr = 0; c1_we = 0; c1_be = '0;
      c2_cs = 0; c2_wr = 0; c2_we = 0; c2_be = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      c0_addr = '0; c0_wd = '0; c0_ba = '0; c0_bd = '0;
      c1_addr = '0; c1_wd = '0; c1_ba = '0; c1_bd = '0;
      c2_addr = '0; c2_wd = '0; c2_ba = '0; c2_bd = '0;
      step();
      step();
      total++; if (c0_rd !== 8'h00) begin bad++; $display("FAIL reset_rd0 got=%h exp=00", c0_rd); end
      total++; if (c0_dv !== 1'b0) begin bad++; $display("FAIL reset_dv0 got=%b exp=0", c0_dv); end
      total++; if (c0_bq !== 32'h0) begin bad++; $display("FAIL reset_bq0 got=%h exp=0", c0_bq); end
      total++; if (c0_cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt0 got=%h exp=00", c0_cnt); end
      total++; if (c1_rd !== 8'h00) begin bad++; $display("FAIL reset_rd1 got=%h exp=00", c1_rd); end
      total++; if (c1_dv !== 1'b0) begin bad++; $display("FAIL reset_dv1 got=%b exp=0", c1_dv); end
      total++; if (c2_rd !== 8'h00) begin bad++; $display("FAIL reset_rd2 got=%h exp=00", c2_rd); end
      total++; if (c2_cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt2 got=%h exp=00", c2_cnt); end
      rst = 1'b0;
      step();
   endtask

   task automatic init_mem();
      for (int i = 0; i < 64; i++) begin
         c0_we = 1; c0_ba = 6'(i); c0_bd = '0; c0_be = 4'hF;
         c1_we = 1; c1_ba = 6'(i); c1_bd = '0; c1_be = 4'hF;
         step();
      end
      idle();
   endtask

   task automatic test_basic();
      c0_cs = 1; c0_wr = 1; c0_addr = 8'h0D; c0_wd = 8'hA5;
      step();
      c0_wr = 0; c0_ba = 6'd3;
      step();
      idle();
      total++; if (c0_bq !== 32'h0000A500) begin bad++; $display("FAIL basic_portb got=%h exp=0000a500", c0_bq); end
      total++; if (c0_dv !== 1'b1) begin bad++; $display("FAIL basic_dv got=%b exp=1", c0_dv); end
      total++; if (c0_rd !== 8'hA5) begin bad++; $display("FAIL basic_rd got=%h exp=a5", c0_rd); end
      step();
      total++; if (c0_dv !== 1'b0) begin bad++; $display("FAIL basic_dv_pulse got=%b exp=0", c0_dv); end
      total++; if (c0_rd !== 8'hA5) begin bad++; $display("FAIL basic_hold got=%h exp=a5", c0_rd); end
   endtask

   task automatic test_burst();
      logic [7:0] exp_b [4];
      exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
      c0_we = 1; c0_ba = 6'd5; c0_bd = 32'h11223344; c0_be = 4'hF;
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         c0_cs = 1; c0_wr = 0; c0_addr = 8'(8'h14 + i);
         step();
         total++; if (c0_dv !== 1'b1) begin bad++; $display("FAIL burst_dv%0d got=%b exp=1", i, c0_dv); end
         total++; if (c0_rd !== exp_b[i]) begin bad++; $display("FAIL burst_rd%0d got=%h exp=%h", i, c0_rd, exp_b[i]); end
      end
      idle();
      step();
      total++; if (c0_dv !== 1'b0) begin bad++; $display("FAIL burst_end_dv got=%b exp=0", c0_dv); end
   endtask

   task automatic test_collision();
      c0_cs = 1; c0_wr = 1; c0_addr = 8'h08; c0_wd = 8'hFF;
      c0_we = 1; c0_ba = 6'd2; c0_bd = 32'h0; c0_be = 4'h1;
      step();
      idle();
      total++; if (c0_cnt !== 8'd1) begin bad++; $display("FAIL coll_cnt1 got=%0d exp=1", c0_cnt); end
      c0_cs = 1; c0_wr = 0; c0_addr = 8'h08;
      step();
      idle();
      total++; if (c0_rd !== 8'h00) begin bad++; $display("FAIL coll_byte_b got=%h exp=00", c0_rd); end
      c0_cs = 1; c0_wr = 1; c0_addr = 8'h08; c0_wd = 8'hFF;
      c0_we = 1; c0_ba = 6'd2; c0_bd = 32'h0; c0_be = 4'hE;
      step();
      idle();
      total++; if (c0_cnt !== 8'd1) begin bad++; $display("FAIL coll_cnt_nocoll got=%0d exp=1", c0_cnt); end
      c0_cs = 1; c0_wr = 0; c0_addr = 8'h08;
      step();
      total++; if (c0_rd !== 8'hFF) begin bad++; $display("FAIL coll_byte_bus got=%h exp=ff", c0_rd); end
      c0_addr = 8'h09;
      step();
      idle();
      total++; if (c0_rd !== 8'h00) begin bad++; $display("FAIL coll_other_lane got=%h exp=00", c0_rd); end
   endtask

   task automatic test_saturation();
      c0_cs = 1; c0_wr = 1; c0_addr = 8'h08; c0_wd = 8'hFF;
      c0_we = 1; c0_ba = 6'd2; c0_bd = 32'h0; c0_be = 4'h1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (i == 252) begin
            total++; if (c0_cnt !== 8'd254) begin bad++; $display("FAIL sat_cnt254 got=%0d exp=254", c0_cnt); end
         end
      end
      idle();
      step();
      total++; if (c0_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt255 got=%0d exp=255", c0_cnt); end
   endtask

   task automatic test_pipe2_reset();
      c1_cs = 1; c1_wr = 1; c1_addr = 8'h21; c1_wd = 8'h5A;
      step();
      c1_wr = 0;
      step();
      idle();
      total++; if (c1_dv !== 1'b0) begin bad++; $display("FAIL pipe2_dv_early got=%b exp=0", c1_dv); end
      step();
      total++; if (c1_dv !== 1'b1) begin bad++; $display("FAIL pipe2_dv got=%b exp=1", c1_dv); end
      total++; if (c1_rd !== 8'h5A) begin bad++; $display("FAIL pipe2_rd got=%h exp=5a", c1_rd); end
      step();
      total++; if (c1_dv !== 1'b0) begin bad++; $display("FAIL pipe2_dv_pulse got=%b exp=0", c1_dv); end
      total++; if (c1_rd !== 8'h5A) begin bad++; $display("FAIL pipe2_hold got=%h exp=5a", c1_rd); end
      c1_cs = 1; c1_wr = 0; c1_addr = 8'h21;
      step();
      idle();
      total++; if (c1_dv !== 1'b0) begin bad++; $display("FAIL pipe2_inflight_dv got=%b exp=0", c1_dv); end
      #2 rst = 1'b1;
      #1;
      total++; if (c1_rd !== 8'h00) begin bad++; $display("FAIL rst_rd1 got=%h exp=00", c1_rd); end
      total++; if (c1_dv !== 1'b0) begin bad++; $display("FAIL rst_dv1 got=%b exp=0", c1_dv); end
      total++; if (c1_bq !== 32'h0) begin bad++; $display("FAIL rst_bq1 got=%h exp=0", c1_bq); end
      total++; if (c0_cnt !== 8'h00) begin bad++; $display("FAIL rst_cnt0 got=%0d exp=0", c0_cnt); end
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (c1_dv !== 1'b0) begin bad++; $display("FAIL rst_no_dv%0d got=%b exp=0", i, c1_dv); end
      end
   endtask

   task automatic test_random();
      logic [7:0] mdl [16];
      logic [7:0] last_rd, exp_rd;
      logic [31:0] exp_bq;
      logic exp_dv, coll;
      int mcnt;
      int a, b;
      mcnt = 0;
      last_rd = 8'h00;
      for (int w = 0; w < 4; w++) begin
         c0_we = 1; c0_ba = 6'(w); c0_bd = $urandom; c0_be = 4'hF;
         for (int k = 0; k < 4; k++) mdl[w*4+k] = c0_bd[8*k +: 8];
         step();
      end
      idle();
      for (int n = 0; n < 500; n++) begin
         c0_cs = 1'($urandom); c0_wr = 1'($urandom);
         a = int'($urandom_range(0, 15)); b = int'($urandom_range(0, 3));
         c0_addr = 8'(a); c0_wd = 8'($urandom);
         c0_we = 1'($urandom); c0_ba = 6'(b); c0_bd = $urandom; c0_be = 4'($urandom);
         exp_bq = {mdl[b*4+3], mdl[b*4+2], mdl[b*4+1], mdl[b*4]};
         exp_dv = c0_cs && !c0_wr;
         if (exp_dv) last_rd = mdl[a];
         exp_rd = last_rd;
         coll = c0_cs && c0_wr && c0_we && (a / 4 == b) && c0_be[a % 4];
         if (coll && mcnt < 255) mcnt++;
         if (c0_cs && c0_wr && !coll) mdl[a] = c0_wd;
         if (c0_we)
            for (int k = 0; k < 4; k++)
               if (c0_be[k]) mdl[b*4+k] = c0_bd[8*k +: 8];
         step();
         total++; if (c0_bq !== exp_bq) begin bad++; $display("FAIL rand_bq n=%0d got=%h exp=%h", n, c0_bq, exp_bq); end
         total++; if (c0_dv !== exp_dv) begin bad++; $display("FAIL rand_dv n=%0d got=%b exp=%b", n, c0_dv, exp_dv); end
         total++; if (c0_rd !== exp_rd) begin bad++; $display("FAIL rand_rd n=%0d got=%h exp=%h", n, c0_rd, exp_rd); end
         total++; if (c0_cnt !== 8'(mcnt)) begin bad++; $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, c0_cnt, mcnt); end
      end
      idle();
      step();
   endtask

   task automatic test_sweep();
      logic [7:0] d [256];
      c2_ba = 8'h00;
      for (int i = 0; i < 256; i++) begin
         d[i] = 8'($urandom);
         c2_cs = 1; c2_wr = 1; c2_addr = 8'(i); c2_wd = d[i];
         step();
      end
      for (int i = 0; i < 256; i++) begin
         c2_cs = 1; c2_wr = 0; c2_addr = 8'(i);
         step();
         total++; if (c2_dv !== 1'b1) begin bad++; $display("FAIL sweep_dv a=%0d got=%b exp=1", i, c2_dv); end
         total++; if (c2_rd !== d[i]) begin bad++; $display("FAIL sweep_rd a=%0d got=%h exp=%h", i, c2_rd, d[i]); end
      end
      idle();
      step();
      total++; if (c2_dv !== 1'b0) begin bad++; $display("FAIL sweep_end_dv got=%b exp=0", c2_dv); end
      total++; if (c2_bq !== d[0]) begin bad++; $display("FAIL sweep_portb got=%h exp=%h", c2_bq, d[0]); end
      total++; if (c2_cnt !== 8'h00) begin bad++; $display("FAIL sweep_cnt got=%0d exp=0", c2_cnt); end
   endtask

   initial begin
      test_reset();
      init_mem();
      test_basic();
      test_burst();
      test_collision();
      test_saturation();
      test_pipe2_reset();
      test_random();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
